// File: rtl/qoi_types.sv
// rtl/qoi_types.sv - shared buffer address/byte types, pass counters and port-B master states
package qoi_types;

    localparam int ADDR_W = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [7:0]        byte_t;
    typedef logic [ADDR_W:0]   cnt_t;

    localparam cnt_t DEPTH = cnt_t'(1 << ADDR_W);

    typedef enum logic [1:0] {
        BSP_IDLE,
        BSP_RUN,
        BSP_FLUSH
    } bsp_state_t;

    // A byte count larger than one buffer saturates at the buffer size.
    function automatic cnt_t clamp_cnt(input cnt_t c);
        return (c > DEPTH) ? DEPTH : c;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small synchronous byte FIFO with flush and occupancy count
module byte_fifo
    import qoi_types::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  byte_t         push_data,
    input  logic          pop,
    input  logic          flush,
    output byte_t         pop_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    byte_t         mem_q [DEPTH];
    byte_t         mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state: a pop frees a slot for a push in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/buffer_stream_port.sv
// rtl/buffer_stream_port.sv - port-B master streaming the input buffer out and the output stream in
module buffer_stream_port
    import qoi_types::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  cnt_t  in_cnt,
    output addr_t addr_b,
    output byte_t data_b_i,
    input  byte_t data_b_o,
    output logic  cs_b,
    output logic  we_b,
    output byte_t rd_data,
    output logic  rd_valid,
    input  logic  rd_ready,
    output logic  rd_end,
    input  byte_t wr_data,
    input  logic  wr_valid,
    input  logic  wr_last,
    output logic  wr_ready,
    output cnt_t  out_cnt,
    output logic  busy,
    output logic  done,
    output logic  ovf
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    bsp_state_t            state_q, state_d;
    cnt_t                  in_cnt_q, in_cnt_d;
    cnt_t                  rd_ptr_q, rd_ptr_d;
    cnt_t                  out_cnt_q, out_cnt_d;
    logic                  ovf_q, ovf_d;
    addr_t                 addr_q, addr_d;
    byte_t                 data_q, data_d;
    logic [RD_LATENCY-1:0] infl_q, infl_d;

    logic [FCW-1:0] fifo_count;
    logic           fifo_empty;
    byte_t          fifo_data;
    logic           run, wr_fire, rd_issue, pop, push, pass_end;
    logic [SW-1:0]  infl_n, occupancy;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_b_o),
        .pop       (pop),
        .flush     (state_q == BSP_FLUSH),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Port-B arbitration (write first), read credit, pass sequencing and held address/data.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        out_cnt_d = out_cnt_q;
        ovf_d     = ovf_q;
        addr_b    = addr_q;
        data_b_i  = data_q;

        run      = (state_q == BSP_RUN);
        wr_ready = run & (out_cnt_q < DEPTH);
        wr_fire  = wr_valid & wr_ready;
        rd_valid = run & ~fifo_empty;
        pop      = rd_valid & rd_ready;
        push     = run & infl_q[RD_LATENCY-1];

        infl_n = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            infl_n = infl_n + SW'(infl_q[i]);
        end
        // A byte leaving the FIFO this cycle frees the slot a new read will need.
        occupancy = SW'(fifo_count) + infl_n - SW'(pop);
        rd_issue  = run & ~wr_fire & (rd_ptr_q < in_cnt_q) & (occupancy < SW'(FIFO_DEPTH));

        cs_b     = wr_fire | rd_issue;
        we_b     = wr_fire;
        pass_end = wr_fire & (wr_last | ((out_cnt_q + cnt_t'(1)) == DEPTH));
        rd_end   = run & (rd_ptr_q == in_cnt_q) & fifo_empty & (infl_n == '0);

        unique case (state_q)
            BSP_IDLE: begin
                if (start) begin
                    in_cnt_d  = clamp_cnt(in_cnt);
                    rd_ptr_d  = '0;
                    out_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = BSP_RUN;
                end
            end
            BSP_RUN: begin
                if (wr_fire) begin
                    addr_b    = out_cnt_q[ADDR_W-1:0];
                    data_b_i  = wr_data;
                    out_cnt_d = out_cnt_q + cnt_t'(1);
                    if (pass_end) begin
                        ovf_d   = ~wr_last;
                        state_d = BSP_FLUSH;
                    end
                end else if (rd_issue) begin
                    addr_b   = rd_ptr_q[ADDR_W-1:0];
                    rd_ptr_d = rd_ptr_q + cnt_t'(1);
                end
            end
            BSP_FLUSH: begin
                state_d = BSP_IDLE;
            end
            default: begin
                state_d = BSP_IDLE;
            end
        endcase

        addr_d = addr_b;
        data_d = data_b_i;
        // Returns still in flight when the pass ends are dropped.
        infl_d = run ? ((infl_q << 1) | RD_LATENCY'(rd_issue)) : '0;
    end

    // State, counters and in-flight shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BSP_IDLE;
            in_cnt_q  <= '0;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            infl_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            infl_q    <= infl_d;
        end
    end

    assign rd_data = fifo_data;
    assign out_cnt = out_cnt_q;
    assign busy    = (state_q != BSP_IDLE);
    assign done    = (state_q == BSP_FLUSH);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_buffer_stream_port.sv
// tb/tb_buffer_stream_port.sv - directed self-checking bench for buffer_stream_port
module tb_buffer_stream_port;
    import qoi_types::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  start = 1'b0;
    cnt_t  in_cnt = '0;
    addr_t addr_b;
    byte_t data_b_i;
    byte_t data_b_o = '0;
    logic  cs_b, we_b;
    byte_t rd_data;
    logic  rd_valid;
    logic  rd_ready = 1'b0;
    logic  rd_end;
    byte_t wr_data = '0;
    logic  wr_valid = 1'b0;
    logic  wr_last = 1'b0;
    logic  wr_ready;
    cnt_t  out_cnt;
    logic  busy, done, ovf;

    byte_t in_buf  [16];
    byte_t out_buf [16];
    byte_t pop_q [$];
    int    pop_cyc [$];
    int    cyc = 0;
    int    n_reads = 0;
    int    n_done = 0;
    int    errors = 0;
    int    checks = 0;

    buffer_stream_port #(.RD_LATENCY(1), .FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_cnt   (in_cnt),
        .addr_b   (addr_b),
        .data_b_i (data_b_i),
        .data_b_o (data_b_o),
        .cs_b     (cs_b),
        .we_b     (we_b),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_end   (rd_end),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .out_cnt  (out_cnt),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Port-B ssram neighbour (one-cycle read latency) plus stream/event monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs_b && we_b) out_buf[addr_b] <= data_b_i;
        if (cs_b && !we_b) begin
            data_b_o <= in_buf[addr_b];
            n_reads  <= n_reads + 1;
        end
        if (rd_valid && rd_ready) begin
            pop_q.push_back(rd_data);
            pop_cyc.push_back(cyc);
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input int n, input logic rdy);
        in_cnt   = cnt_t'(n);
        rd_ready = rdy;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        #1;
    endtask

    task automatic wait_rd_end(input string tag, input int budget);
        int n = 0;
        while (rd_end !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(rd_end), 32'd1);
    endtask

    task automatic end_pass(input byte_t b);
        wr_valid = 1'b1;
        wr_data  = b;
        wr_last  = 1'b1;
        #1;
        chk("end_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        #1;
        chk("end_done", 32'(done), 32'd1);
        tick();
        chk("end_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        int base, r0, d0;

        // Reset state
        #2;
        chk("rst_cs", 32'(cs_b), 32'd0);
        chk("rst_we", 32'(we_b), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_end", 32'(rd_end), 32'd0);
        chk("rst_addr", 32'(addr_b), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: four bytes streamed in order, one per cycle after the fill
        in_buf[0] = 8'h11; in_buf[1] = 8'h22; in_buf[2] = 8'h33; in_buf[3] = 8'h44;
        base = pop_q.size();
        start_pass(4, 1'b1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_first_read_addr", 32'(addr_b), 32'd0);
        wait_rd_end("t1_rd_end", 20);
        chk("t1_pop0", 32'(pop_q[base]), 32'h11);
        chk("t1_pop1", 32'(pop_q[base + 1]), 32'h22);
        chk("t1_pop2", 32'(pop_q[base + 2]), 32'h33);
        chk("t1_pop3", 32'(pop_q[base + 3]), 32'h44);
        chk("t1_pop_count", 32'(pop_q.size() - base), 32'd4);
        chk("t1_rate", 32'(pop_cyc[base + 3] - pop_cyc[base]), 32'd3);
        end_pass(8'h5A);
        chk("t1_out_buf0", 32'(out_buf[0]), 32'h5A);

        // 2: consumer stalled -> reads stop at FIFO depth, nothing lost on release
        for (int i = 0; i < 16; i++) in_buf[i] = byte_t'(8'h40 + i);
        base = pop_q.size();
        start_pass(8, 1'b0);
        r0 = n_reads;
        repeat (10) tick();
        chk("t2_reads_stalled", 32'(n_reads - r0), 32'd2);
        chk("t2_cs_idle", 32'(cs_b), 32'd0);
        chk("t2_rd_valid", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        wait_rd_end("t2_rd_end", 30);
        for (int i = 0; i < 8; i++) chk("t2_pop", 32'(pop_q[base + i]), 32'(8'h40 + i));
        chk("t2_pop_count", 32'(pop_q.size() - base), 32'd8);
        end_pass(8'h77);

        // 3: three writes interleaved with reads, last on the third
        start_pass(6, 1'b1);
        chk("t3_r0_read", 32'({cs_b, we_b}), 32'b10);
        tick();
        r0 = n_reads;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = byte_t'(8'hA0 + i);
            wr_last  = (i == 2);
            #1;
            chk("t3_wr_cs_we", 32'({cs_b, we_b}), 32'b11);
            chk("t3_wr_addr", 32'(addr_b), 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        #1;
        chk("t3_no_reads_on_writes", 32'(n_reads - r0), 32'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_out_cnt", 32'(out_cnt), 32'd3);
        chk("t3_ovf", 32'(ovf), 32'd0);
        chk("t3_rd_valid_flush", 32'(rd_valid), 32'd0);
        chk("t3_wr_ready_flush", 32'(wr_ready), 32'd0);
        chk("t3_busy_flush", 32'(busy), 32'd1);
        tick();
        chk("t3_done_one_cycle", 32'(done), 32'd0);
        chk("t3_busy_fall", 32'(busy), 32'd0);
        chk("t3_out_buf0", 32'(out_buf[0]), 32'hA0);
        chk("t3_out_buf1", 32'(out_buf[1]), 32'hA1);
        chk("t3_out_buf2", 32'(out_buf[2]), 32'hA2);

        // 4 + 5a: in_cnt=0 (no reads), DEPTH writes without wr_last -> overflow
        start_pass(0, 1'b1);
        chk("t4_rd_end_first", 32'(rd_end), 32'd1);
        chk("t4_cs_idle", 32'(cs_b), 32'd0);
        r0 = n_reads;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = byte_t'(8'hC0 + i);
            #1;
            chk("t4_wr_addr", 32'(addr_b), 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_out_cnt", 32'(out_cnt), 32'd16);
        chk("t4_wr_ready_low", 32'(wr_ready), 32'd0);
        chk("t4_no_reads", 32'(n_reads - r0), 32'd0);
        tick();
        chk("t4_ovf_held", 32'(ovf), 32'd1);
        chk("t4_busy_fall", 32'(busy), 32'd0);
        chk("t4_out_buf0", 32'(out_buf[0]), 32'hC0);
        chk("t4_out_buf15", 32'(out_buf[15]), 32'hCF);

        // 5b: in_cnt beyond DEPTH clamps to exactly DEPTH reads
        for (int i = 0; i < 16; i++) in_buf[i] = byte_t'(8'h80 + i);
        base = pop_q.size();
        r0 = n_reads;
        start_pass(21, 1'b1);
        chk("t5_ovf_cleared", 32'(ovf), 32'd0);
        wait_rd_end("t5_rd_end", 60);
        chk("t5_reads", 32'(n_reads - r0), 32'd16);
        for (int i = 0; i < 16; i++) chk("t5_pop", 32'(pop_q[base + i]), 32'(8'h80 + i));
        end_pass(8'h99);

        // 6: asynchronous reset mid-pass with reads outstanding
        start_pass(8, 1'b0);
        tick();
        tick();
        d0 = n_done;
        #2;
        rst = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cs", 32'(cs_b), 32'd0);
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_wr_ready", 32'(wr_ready), 32'd0);
        chk("t6_addr", 32'(addr_b), 32'd0);
        chk("t6_rd_data", 32'(rd_data), 32'd0);
        chk("t6_rd_end", 32'(rd_end), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        base = pop_q.size();
        start_pass(2, 1'b1);
        wait_rd_end("t6_rd_end_after", 20);
        chk("t6_pop0", 32'(pop_q[base]), 32'h80);
        chk("t6_pop1", 32'(pop_q[base + 1]), 32'h81);
        end_pass(8'h55);
        chk("t6_out_buf0", 32'(out_buf[0]), 32'h55);
        chk("t6_done_count", 32'(n_done - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
